// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port integer register file.
// Imported by the clear sequencer and the register file top.
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  localparam int X0_IDX = 0;

  // Bit offset of port `port` inside a packed vector of `width`-bit fields
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of read, write, scoreboard and clear signals between the core and regfile_mp.
// The master side is decode/issue plus writeback; the slave side is the register file.
interface regfile_mp_if #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    localparam int IDXW = $clog2(NREGS);

    logic                     clr_req;
    logic                     ready;
    logic [NUM_RD*IDXW-1:0]   rd_idx;
    logic [NUM_RD*XLEN-1:0]   rd_data;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*IDXW-1:0]   wr_idx;
    logic [NUM_WR*XLEN-1:0]   wr_data;
    logic                     sb_set;
    logic [IDXW-1:0]          sb_idx;
    logic [NREGS-1:0]         busy;

    modport master (
        output clr_req, rd_idx, wr_en, wr_idx, wr_data, sb_set, sb_idx,
        input  ready, rd_data, busy
    );

    modport slave (
        input  clr_req, rd_idx, wr_en, wr_idx, wr_data, sb_set, sb_idx,
        output ready, rd_data, busy
    );

endinterface

// File: rtl/regfile_clear_seq.sv
// CLEAR/RUN sequencer: walks cnt over x1..x(NREGS-1) issuing one zero-write per cycle.
// Resets into CLEAR; re-enters CLEAR from RUN on clr_req.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter  int NREGS = 32,
    localparam int IDXW  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_req_i,
    output logic            ready_o,
    output logic            clr_we_o,
    output logic [IDXW-1:0] clr_idx_o
);

    localparam logic [IDXW-1:0] CNT_FIRST = IDXW'(1);
    localparam logic [IDXW-1:0] CNT_LAST  = IDXW'(NREGS - 1);

    rf_state_e       state_q, state_d;
    logic [IDXW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RF_RUN) begin
            if (clr_req_i) begin
                state_d = RF_CLEAR;
                cnt_d   = CNT_FIRST;
            end
        end else begin
            // The zero-write to the last register completes the sweep
            if (cnt_q == CNT_LAST) begin
                state_d = RF_RUN;
                cnt_d   = CNT_FIRST;
            end else begin
                cnt_d = cnt_q + IDXW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            cnt_q   <= CNT_FIRST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready_o   = (state_q == RF_RUN);
    assign clr_we_o  = (state_q == RF_CLEAR);
    assign clr_idx_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired-zero x0, optional write-to-read bypass,
// pending-write scoreboard and a sequential zeroing engine in place of an array reset.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int NREGS  = 32,
    parameter  int NUM_RD = 2,
    parameter  int NUM_WR = 1,
    parameter  int BYPASS = 1,
    localparam int IDXW   = $clog2(NREGS)
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    localparam logic [IDXW-1:0] X0 = IDXW'(X0_IDX);

    logic            ready;
    logic            clr_we;
    logic [IDXW-1:0] clr_idx;

    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [NREGS-1:0] busy_q, busy_d;

    logic [IDXW-1:0] rd_idx_a  [NUM_RD];
    logic [XLEN-1:0] rd_val    [NUM_RD];
    logic [IDXW-1:0] wr_idx_a  [NUM_WR];
    logic [XLEN-1:0] wr_data_a [NUM_WR];
    logic            wr_hit    [NUM_WR];

    regfile_clear_seq #(
        .NREGS (NREGS)
    ) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .clr_req_i (bus.clr_req),
        .ready_o   (ready),
        .clr_we_o  (clr_we),
        .clr_idx_o (clr_idx)
    );

    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_idx_a[p] = bus.rd_idx[port_lsb(p, IDXW) +: IDXW];
        end
        for (int w = 0; w < NUM_WR; w++) begin
            wr_idx_a[w]  = bus.wr_idx[port_lsb(w, IDXW) +: IDXW];
            wr_data_a[w] = bus.wr_data[port_lsb(w, XLEN) +: XLEN];
            wr_hit[w]    = bus.wr_en[w] && (wr_idx_a[w] != X0);
        end
    end

    // Clear-engine zero-write takes the array write path in CLEAR; later ports win in RUN
    always_ff @(posedge clk) begin
        if (clr_we) begin
            regs_q[clr_idx] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_hit[w]) begin
                    regs_q[wr_idx_a[w]] <= wr_data_a[w];
                end
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_val[p] = '0;
            if (ready && (rd_idx_a[p] != X0)) begin
                rd_val[p] = regs_q[rd_idx_a[p]];
                if (BYPASS != 0) begin
                    for (int w = 0; w < NUM_WR; w++) begin
                        if (wr_hit[w] && (wr_idx_a[w] == rd_idx_a[p])) begin
                            rd_val[p] = wr_data_a[w];
                        end
                    end
                end
            end
            bus.rd_data[port_lsb(p, XLEN) +: XLEN] = rd_val[p];
        end
    end

    // Set is applied after the clears so a newly issued producer supersedes a retiring one
    always_comb begin
        busy_d = busy_q;
        if (!ready || bus.clr_req) begin
            busy_d = '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_hit[w]) begin
                    busy_d[wr_idx_a[w]] = 1'b0;
                end
            end
            if (bus.sb_set && (bus.sb_idx != X0)) begin
                busy_d[bus.sb_idx] = 1'b1;
            end
        end
        busy_d[X0_IDX] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.ready = ready;
    assign bus.busy  = busy_q;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core, replacing the fixed 2-read/1-write file. It provides configurable read and write port counts, a hardwired-zero x0, optional write-to-read bypass, and a per-register pending-write scoreboard for issue hazard checks. The array has no async reset; after reset or on request, a sequential clear engine zeroes it one register per cycle. The block sits between decode/issue (reads, scoreboard) and writeback (writes).

## Interface
- XLEN, 32, data width
- NREGS, 32, register count; power of two, ≥4
- NUM_RD, 2, read ports
- NUM_WR, 1, write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads
- IDXW, derived $clog2(NREGS), index width; not overridable
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clr_req  in  1  start full-array clear; honoured only when ready=1
- ready  out  1  1 = RUN state; 0 = clear in progress
- rd_idx  in  NUM_RD*IDXW  read indices, port p at [p*IDXW +: IDXW]
- rd_data  out  NUM_RD*XLEN  read data, combinational
- wr_en  in  NUM_WR  per-port write enable
- wr_idx  in  NUM_WR*IDXW  write indices
- wr_data  in  NUM_WR*XLEN  write data
- sb_set  in  1  mark sb_idx pending (instruction issued)
- sb_idx  in  IDXW  scoreboard set index
- busy  out  NREGS  pending-write bit per register

## Operation
- States: CLEAR, RUN. rst → CLEAR, clear counter cnt=1, busy=0, ready=0.
- CLEAR: each cycle writes 0 to reg[cnt] and increments cnt. When the write with cnt=NREGS-1 completes, the next state is RUN. Clearing therefore takes NREGS-1 cycles after rst deasserts.
- In CLEAR: all wr_en and sb_set are ignored, and every rd_data = 0.
- RUN: ready=1. clr_req=1 → CLEAR next cycle with cnt=1 and busy cleared. Writes in that same cycle still commit, but are overwritten by the clear.
- Index 0 is never stored. Writes to x0 are dropped. Reads of x0 return 0. busy[0] stays 0.
- Writes: on the clock edge, for every p with wr_en[p] and wr_idx[p]≠0, reg[wr_idx[p]] ← wr_data[p]. If several ports hit the same index, the highest-numbered port wins.
- Reads: rd_data[p] = reg[rd_idx[p]]. With BYPASS=1, a same-cycle enabled write to the same nonzero index forwards its wr_data instead, using the same highest-port-wins rule. With BYPASS=0, the reader sees the old value.
- Scoreboard, per edge in RUN:
  - An enabled write to idx≠0 clears busy[idx].
  - sb_set with sb_idx≠0 sets busy[sb_idx].
  - Set and clear on the same index in one cycle → set wins, because a new producer supersedes the old one.
- Idempotent cases: setting an already-busy bit leaves it 1. A write to a non-busy register leaves its bit 0.

## Timing
- Reset values: ready=0, busy=0, rd_data=0 (CLEAR state). State and cnt reset asynchronously. The array itself is not reset.
- Write-to-read latency: 1 cycle, or 0 with BYPASS=1.
- Scoreboard update is visible on busy the cycle after the edge.
- clr_req → ready falls the next cycle and returns after NREGS-1 cycles of CLEAR.
- rst asserted mid-clear restarts the clear from cnt=1.
- rd_data is combinational from rd_idx, wr_*, and state. There are no registered outputs besides ready and busy.

## Structure
- Shared package regfile_pkg:
  - state enum {RF_CLEAR, RF_RUN}
  - helper function for index slicing of packed port vectors
  - x0 index constant
- Sub-module regfile_clear_seq: owns the state register, cnt, and the ready/clear-write signals. The parent muxes its zero-write into the array write path.
- Scoreboard and bypass logic stay in regfile_mp.

## Test plan
- Reset, then rst low → ready=0 for 31 cycles (NREGS=32) and 1 afterwards. Reads of any index during CLEAR return 0. Reads after CLEAR return 0 for all 32 indices.
- RUN:
  - write x5=0xDEADBEEF, then read port 1 at idx 5 next cycle → 0xDEADBEEF.
  - write x0=0x1234 → x0 still reads 0.
- NUM_WR=2, both ports write x7 (0x11, 0x22) in one cycle → x7=0x22. With BYPASS=1, a same-cycle read of x7 returns 0x22. With BYPASS=0, it returns the previous value.
- Scoreboard:
  - sb_set idx 3 → busy[3]=1 next cycle.
  - write x3 → busy[3]=0.
  - Same cycle sb_set idx 3 and write x3 → busy[3]=1.
  - sb_set idx 0 → busy stays 0.
- clr_req after populating x1..x31 → ready=0 next cycle and sb_set ignored. After 31 cycles, all regs read 0 and busy=0.
- rst pulsed at cnt=10 mid-clear → a full 31-cycle clear restarts. Writes during CLEAR have no effect.
